// File: rtl/frame_sched.sv
// Frame scheduler: wraps an AXI-stream payload into fixed PAM4 frames of
// LENGTH_M_SEQ pilot chips, LENGTH_DATA data symbols and GUARD_LEN guard symbols.
// Ports:
//   clk, arst_n          - clock (rising edge) and async active-low reset
//   enable               - permits new frames to start
//   M_AXIS_t*            - payload word stream in (tready is registered)
//   sym_data/pilot/valid - symbol stream out, sym_ready is the downstream accept
//   frame_cnt            - completed-frame counter (wraps)
//   busy                 - not idle
//   underrun_err         - sticky, set when a data word slot had to be zero-filled
module frame_sched #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LENGTH_M_SEQ = 31,
    parameter int unsigned LENGTH_DATA  = 32,
    parameter int unsigned GUARD_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                  M_AXIS_tvalid,
    input  logic                  M_AXIS_tlast,
    output logic                  M_AXIS_tready,
    output logic [1:0]            sym_data,
    output logic                  sym_pilot,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [15:0]           frame_cnt,
    output logic                  busy,
    output logic                  underrun_err
);

    localparam int unsigned SYM_PER_WORD    = DATA_WIDTH / 2;
    localparam int unsigned WORDS_PER_FRAME = LENGTH_DATA / SYM_PER_WORD;
    localparam int unsigned CNT_W           = 16;
    localparam logic [4:0]  LFSR_SEED       = 5'b00001;

    typedef enum logic [1:0] {S_IDLE, S_PILOT, S_DATA, S_GUARD} state_t;

    state_t                state_q, state_d;
    logic [4:0]            lfsr_q, lfsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      words_q, words_d;
    logic                  tlast_seen_q, tlast_seen_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]            sym_data_d;
    logic                  sym_pilot_d, sym_valid_d, tready_d, busy_d, underrun_d;
    logic [15:0]           frame_cnt_d;

    logic                  accept, word_take, start_ok, enter_pilot, load_word;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] boundary_word;

    // x^5 + x^2 + 1 Fibonacci step; lfsr_q always holds the state of the next chip
    function automatic logic [4:0] lfsr_next(input logic [4:0] l);
        return {l[0] ^ l[2], l[4:1]};
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        words_d      = words_q;
        tlast_seen_d = tlast_seen_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        shreg_d      = shreg_q;
        sym_data_d   = sym_data;
        sym_pilot_d  = sym_pilot;
        sym_valid_d  = sym_valid;
        frame_cnt_d  = frame_cnt;
        underrun_d   = underrun_err;
        enter_pilot  = 1'b0;
        load_word    = 1'b0;

        accept        = sym_valid && sym_ready;
        word_take     = M_AXIS_tready && M_AXIS_tvalid;
        start_ok      = enable && M_AXIS_tvalid;
        cnt_inc       = cnt_q + CNT_W'(1);
        boundary_word = buf_full_q ? buf_q : '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) enter_pilot = 1'b1;
            end
            S_PILOT: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(LENGTH_M_SEQ - 1)) begin
                        state_d   = S_DATA;
                        cnt_d     = '0;
                        load_word = 1'b1;
                    end else begin
                        cnt_d      = cnt_inc;
                        sym_data_d = {2{lfsr_q[0]}};
                        lfsr_d     = lfsr_next(lfsr_q);
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(LENGTH_DATA - 1)) begin
                        state_d     = S_GUARD;
                        cnt_d       = '0;
                        sym_data_d  = 2'b00;
                        sym_pilot_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        if ((cnt_inc % CNT_W'(SYM_PER_WORD)) == '0) begin
                            load_word = 1'b1;
                        end else begin
                            sym_data_d = shreg_q[DATA_WIDTH-1 -: 2];
                            shreg_d    = shreg_q << 2;
                        end
                    end
                end
            end
            S_GUARD: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
                        frame_cnt_d = frame_cnt + 16'd1;
                        buf_full_d  = 1'b0;     // words never straddle frames
                        if (start_ok) begin
                            enter_pilot = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            sym_valid_d = 1'b0;
                            sym_data_d  = 2'b00;
                            sym_pilot_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Word boundary: take the prefetched word, or zeros if none arrived
        if (load_word) begin
            sym_data_d  = boundary_word[DATA_WIDTH-1 -: 2];
            shreg_d     = boundary_word << 2;
            sym_pilot_d = 1'b0;
            buf_full_d  = 1'b0;
            if (!buf_full_q && !tlast_seen_q) underrun_d = 1'b1;
        end

        // Frame start: first chip comes from the seed, symbol valid next cycle
        if (enter_pilot) begin
            state_d      = S_PILOT;
            lfsr_d       = lfsr_next(LFSR_SEED);
            cnt_d        = '0;
            words_d      = '0;
            tlast_seen_d = 1'b0;
            buf_full_d   = 1'b0;
            sym_valid_d  = 1'b1;
            sym_pilot_d  = 1'b1;
            sym_data_d   = {2{LFSR_SEED[0]}};
        end

        // tready implies the buffer is empty, so this never overwrites a word
        if (word_take) begin
            buf_d        = M_AXIS_tdata;
            buf_full_d   = 1'b1;
            words_d      = words_q + CNT_W'(1);
            tlast_seen_d = tlast_seen_q || M_AXIS_tlast;
        end

        tready_d = !buf_full_d && (state_d == S_PILOT || state_d == S_DATA) &&
                   (words_d < CNT_W'(WORDS_PER_FRAME)) && !tlast_seen_d;
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            cnt_q         <= '0;
            words_q       <= '0;
            tlast_seen_q  <= 1'b0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            shreg_q       <= '0;
            sym_data      <= 2'b00;
            sym_pilot     <= 1'b0;
            sym_valid     <= 1'b0;
            M_AXIS_tready <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            underrun_err  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            words_q       <= words_d;
            tlast_seen_q  <= tlast_seen_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            shreg_q       <= shreg_d;
            sym_data      <= sym_data_d;
            sym_pilot     <= sym_pilot_d;
            sym_valid     <= sym_valid_d;
            M_AXIS_tready <= tready_d;
            busy          <= busy_d;
            frame_cnt     <= frame_cnt_d;
            underrun_err  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: scoreboard of expected symbols built
// from a reference frame model, compared on every accepted symbol.
module tb_frame_sched;

    localparam int FRAME_SYMS = 67;
    localparam logic [1:0] FIRST_CHIPS [6] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tlast;
    logic        M_AXIS_tready;
    logic [1:0]  sym_data;
    logic        sym_pilot;
    logic        sym_valid;
    logic        sym_ready;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        underrun_err;

    frame_sched dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .enable        (enable),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tready (M_AXIS_tready),
        .sym_data      (sym_data),
        .sym_pilot     (sym_pilot),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .frame_cnt     (frame_cnt),
        .busy          (busy),
        .underrun_err  (underrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  sb_q [$];     // {pilot, data}
    logic [32:0] src_q [$];    // {tlast, tdata}
    int          frame_idx   = 0;
    int          frames_done = 0;
    int          valid_cycles = 0;
    int          tready_viol = 0;
    bit          hold_pending = 1'b0;
    bit          tlast_seen   = 1'b0;
    bit          toggle_mode  = 1'b0;
    logic [2:0]  held_sym = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: m-sequence pilot, two words MSB-first, zero guard
    task automatic push_frame(input logic [31:0] d0, input logic [31:0] d1);
        logic [4:0]  lf;
        logic [31:0] w;
        lf = 5'b00001;
        for (int i = 0; i < 31; i++) begin
            sb_q.push_back({1'b1, lf[0], lf[0]});
            lf = {lf[0] ^ lf[2], lf[4:1]};
        end
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? d0 : d1;
            for (int s = 0; s < 16; s++) sb_q.push_back({1'b0, 2'(w >> (30 - 2 * s))});
        end
        for (int g = 0; g < 4; g++) sb_q.push_back(3'b000);
    endtask

    // One cycle: observe at negedge, drive inputs, book handshakes for the next posedge
    task automatic tick();
        logic [2:0] got;
        logic [2:0] exp;
        @(negedge clk);
        got = {sym_pilot, sym_data};
        if (hold_pending) check("hold", 32'(got), 32'(held_sym));
        if (sym_valid) valid_cycles++;
        if (tlast_seen && M_AXIS_tready) tready_viol++;

        sym_ready = toggle_mode ? (sym_valid ? ~sym_ready : 1'b1) : 1'b1;
        M_AXIS_tvalid = (src_q.size() > 0);
        M_AXIS_tdata  = (src_q.size() > 0) ? src_q[0][31:0] : 32'h0;
        M_AXIS_tlast  = (src_q.size() > 0) ? src_q[0][32] : 1'b0;

        if (sym_valid && sym_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check("sym", 32'(got), 32'(exp));
                if (frame_idx < 6) check("chip", 32'(sym_data), 32'(FIRST_CHIPS[3'(frame_idx)]));
                frame_idx++;
                if (frame_idx == FRAME_SYMS) begin
                    frame_idx = 0;
                    frames_done++;
                end
            end
        end
        hold_pending = sym_valid && !sym_ready;
        held_sym     = got;

        if (M_AXIS_tvalid && M_AXIS_tready) begin
            if (src_q[0][32]) tlast_seen = 1'b1;
            void'(src_q.pop_front());
        end
    endtask

    task automatic run_frame(input logic [31:0] w0, input bit last0, input bit give_w1,
                             input logic [31:0] w1, input bit extra, input int drop_at,
                             input bit toggle, input int exp_valid, input bit exp_underrun);
        int start_frames;
        push_frame(w0, (give_w1 && !last0) ? w1 : 32'h0);
        src_q.push_back({last0, w0});
        if (give_w1) src_q.push_back({1'b0, w1});
        if (extra) src_q.push_back({1'b0, 32'hA5A5_5A5A});
        toggle_mode  = toggle;
        tlast_seen   = 1'b0;
        tready_viol  = 0;
        valid_cycles = 0;
        start_frames = frames_done;
        enable       = 1'b1;
        for (int c = 0; c < 600 && frames_done == start_frames; c++) begin
            tick();
            if (drop_at < 0 ? sym_valid : (frame_idx >= drop_at)) enable = 1'b0;
        end
        if (frames_done == start_frames) check("frame_timeout", 32'(frames_done), 32'(start_frames + 1));
        enable = 1'b0;
        repeat (3) tick();
        check("idle_valid", 32'(sym_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tready", 32'(M_AXIS_tready), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(16'(frames_done)));
        check("underrun", 32'(underrun_err), 32'(exp_underrun));
        check("sb_left", 32'(sb_q.size()), 32'd0);
        check("valid_cycles", 32'(valid_cycles), 32'(exp_valid));
        check("tready_after_tlast", 32'(tready_viol), 32'd0);
        src_q.delete();
        toggle_mode = 1'b0;
        tick();
    endtask

    initial begin
        arst_n        = 1'b0;
        enable        = 1'b0;
        M_AXIS_tdata  = '0;
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tlast  = 1'b0;
        sym_ready     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(sym_valid), 32'd0);
        check("rst_data", 32'(sym_data), 32'd0);
        check("rst_pilot", 32'(sym_pilot), 32'd0);
        check("rst_tready", 32'(M_AXIS_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_underrun", 32'(underrun_err), 32'd0);
        arst_n = 1'b1;
        tick();

        // Nominal frame, ready always high
        run_frame(32'h1234_5670, 1'b0, 1'b1, 32'h1234_5671, 1'b0, -1, 1'b0, 67, 1'b0);
        // Backpressure: ready alternates, every symbol held one cycle
        run_frame(32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0F0F_A5A5, 1'b0, -1, 1'b1, 134, 1'b0);
        // tlast on first word: legal zero padding, no further words taken
        run_frame(32'hCAFE_F00D, 1'b1, 1'b1, 32'h1111_1111, 1'b0, -1, 1'b0, 67, 1'b0);
        // enable drops at chip 10 with data still pending: frame completes, then idle
        run_frame(32'h89AB_CDEF, 1'b0, 1'b1, 32'h7654_3210, 1'b1, 10, 1'b0, 67, 1'b0);
        // Starvation after first word: zero fill and sticky underrun
        run_frame(32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 1'b0, -1, 1'b0, 67, 1'b1);
        repeat (5) tick();
        check("underrun_sticky", 32'(underrun_err), 32'd1);

        // Asynchronous reset during DATA
        push_frame(32'h0BAD_CAFE, 32'h600D_F00D);
        src_q.push_back({1'b0, 32'h0BAD_CAFE});
        src_q.push_back({1'b0, 32'h600D_F00D});
        enable = 1'b1;
        for (int c = 0; c < 300 && frame_idx < 40; c++) begin
            tick();
            if (sym_valid) enable = 1'b0;
        end
        check("rst_in_data", 32'(frame_idx >= 40 && frame_idx < 62), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("arst_valid", 32'(sym_valid), 32'd0);
        check("arst_data", 32'(sym_data), 32'd0);
        check("arst_pilot", 32'(sym_pilot), 32'd0);
        check("arst_tready", 32'(M_AXIS_tready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("arst_underrun", 32'(underrun_err), 32'd0);
        sb_q.delete();
        src_q.delete();
        frame_idx    = 0;
        frames_done  = 0;
        hold_pending = 1'b0;
        enable       = 1'b0;
        repeat (2) tick();
        arst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(sym_valid), 32'd0);
        run_frame(32'h1357_9BDF, 1'b0, 1'b1, 32'h2468_ACE0, 1'b0, -1, 1'b0, 67, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the AXI-stream input word.
REQ-002 SHALL have parameter LENGTH_M_SEQ, default 31: number of pilot chips per frame.
REQ-003 SHALL have parameter LENGTH_DATA, default 32: number of data symbols per frame (2 words at PAM4).
REQ-004 SHALL have parameter GUARD_LEN, default 4: number of zero-level guard symbols per frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: permits new frames to start.
REQ-008 SHALL have port M_AXIS_tdata, input, DATA_WIDTH bits: payload word.
REQ-009 SHALL have port M_AXIS_tvalid, input, 1 bit: payload word valid.
REQ-010 SHALL have port M_AXIS_tlast, input, 1 bit: last word of the packet.
REQ-011 SHALL have port M_AXIS_tready, output, 1 bit: the block accepts a word.
REQ-012 SHALL have port sym_data, output, 2 bits: PAM4 symbol code.
REQ-013 SHALL have port sym_pilot, output, 1 bit: the current symbol is a pilot chip.
REQ-014 SHALL have port sym_valid, output, 1 bit: symbol valid.
REQ-015 SHALL have port sym_ready, input, 1 bit: the mapper accepts the symbol.
REQ-016 SHALL have port frame_cnt, output, 16 bits: count of completed frames.
REQ-017 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-018 SHALL have port underrun_err, output, 1 bit: sticky flag set on data starvation.

Function
REQ-019 SHALL implement the states IDLE, PILOT, DATA and GUARD, with 2 bits per symbol (PAM_ORDER 4 fixed).
REQ-020 SHALL leave IDLE for PILOT when enable and M_AXIS_tvalid are both sampled high; sym_valid SHALL rise on the next cycle.
REQ-021 SHALL advance a symbol only on sym_valid && sym_ready; sym_data and sym_pilot SHALL hold while sym_valid && !sym_ready.
REQ-022 SHALL keep sym_valid high continuously from PILOT entry through the last GUARD symbol (no bubbles).
REQ-023 SHALL reload a 5-bit LFSR to 5'b00001 on PILOT entry, emitting chip = lfsr[0] and updating next = {lfsr[0]^lfsr[2], lfsr[4:1]} (x^5+x^2+1, period 31).
REQ-024 SHALL map chip 1 to sym_data 2'b11 and chip 0 to 2'b00, with sym_pilot=1 throughout PILOT.
REQ-025 SHALL move from PILOT to DATA after LENGTH_M_SEQ chips are accepted.
REQ-026 SHALL provide a one-word prefetch buffer plus a symbol shift register.
REQ-027 SHALL drive M_AXIS_tready = buffer empty && state in {PILOT, DATA} && words taken this frame < LENGTH_DATA/16 && no tlast taken this frame.
REQ-028 SHALL emit data symbols MSB-first (word[31:30] first, word[1:0] last), with sym_pilot=0.
REQ-029 SHALL, at each 16-symbol word boundary, load the shift register from the buffer when it is full.
REQ-030 SHALL, at a word boundary with the buffer empty, load the shift register with zeros.
REQ-031 SHALL set underrun_err at such a zero load, unless tlast was already taken this frame (that padding is legal).
REQ-032 SHALL move from DATA to GUARD after LENGTH_DATA symbols and then emit GUARD_LEN symbols of 2'b00 with sym_pilot=0.
REQ-033 SHALL, on acceptance of the last GUARD symbol, increment frame_cnt (wrapping 16'hFFFF to 0).
REQ-034 SHALL, after the last GUARD symbol, go to PILOT when enable && M_AXIS_tvalid, or to IDLE otherwise (sym_valid low in IDLE).
REQ-035 SHALL, when enable falls mid-frame, complete the current frame before returning to IDLE.
REQ-036 SHALL discard any word still in the prefetch buffer at frame end, since a word is never split across frames.

Reset
REQ-037 SHALL, on arst_n low at any time, immediately enter IDLE.
REQ-038 SHALL, on reset, force sym_valid=0, sym_data=2'b00, sym_pilot=0, M_AXIS_tready=0, busy=0, frame_cnt=0 and underrun_err=0.
REQ-039 SHALL, on reset, clear the buffer and load the LFSR with 5'b00001.
REQ-040 SHALL, on reset release, restart any partial frame from PILOT; no residual symbols are emitted.

Verification
REQ-041 SHALL be verified by: enable=1, tvalid=1, sym_ready=1, data 32'h1234_5670/71 -> one frame of 67 symbols; first chips 3,0,0,0,0,3; data symbols start 0,1,0,2; guard 0,0,0,0; frame_cnt=1.
REQ-042 SHALL be verified by: sym_ready toggled 1/0 every cycle -> identical symbol sequence, each symbol held while ready is low; frame takes 134 cycles.
REQ-043 SHALL be verified by: tvalid dropped after the first data word, no tlast -> second word emitted as 16 zeros and underrun_err=1 (sticky until reset).
REQ-044 SHALL be verified by: tlast on the first word -> second word zero-padded, underrun_err stays 0, tready low for the rest of the frame.
REQ-045 SHALL be verified by: enable deasserted at pilot chip 10 -> frame completes all 67 symbols, then IDLE with sym_valid=0 and busy=0.
REQ-046 SHALL be verified by: arst_n pulsed low during DATA -> outputs reach reset values asynchronously; the next frame's first chips are 3,0,0,0,0,3.
